// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared types and constants for the memory-access stage
package core_pkg;

  localparam int XLEN       = 32;
  localparam int BYTE_W     = 8;
  localparam int HALF_W     = 16;
  localparam int GPR_ADDR_W = 5;
  localparam int CSR_ADDR_W = 14;

  typedef enum logic [3:0] {
    LSU_NONE  = 4'd0,
    LSU_LD_B  = 4'd1,
    LSU_LD_H  = 4'd2,
    LSU_LD_W  = 4'd3,
    LSU_LD_BU = 4'd4,
    LSU_LD_HU = 4'd5,
    LSU_ST_B  = 4'd6,
    LSU_ST_H  = 4'd7,
    LSU_ST_W  = 4'd8
  } lsu_op_t;

  typedef enum logic [2:0] {
    MS_IDLE,
    MS_REQ,
    MS_WAIT,
    MS_DONE,
    MS_DRAIN
  } mem_state_t;

  typedef struct packed {
    logic [XLEN-1:0]       pc;
    logic [XLEN-1:0]       inst;
    logic [XLEN-1:0]       ex_result;
    logic                  rw_en;
    logic [GPR_ADDR_W-1:0] rw_addr;
    logic [XLEN-1:0]       lsu_data;
    lsu_op_t               lsu_op;
    logic                  csr_en;
    logic [CSR_ADDR_W-1:0] csr_addr;
    logic [XLEN-1:0]       csr_data;
  } mem_bundle_t;

  typedef struct packed {
    logic [XLEN-1:0]       pc;
    logic [XLEN-1:0]       inst;
    logic [XLEN-1:0]       rw_data;
    logic                  rw_en;
    logic [GPR_ADDR_W-1:0] rw_addr;
    logic                  csr_en;
    logic [CSR_ADDR_W-1:0] csr_addr;
    logic [XLEN-1:0]       csr_data;
    logic                  ale;
    logic [XLEN-1:0]       badv;
  } wb_bundle_t;

  function automatic logic lsu_is_load(lsu_op_t op);
    return op inside {LSU_LD_B, LSU_LD_H, LSU_LD_W, LSU_LD_BU, LSU_LD_HU};
  endfunction

  function automatic logic lsu_is_store(lsu_op_t op);
    return op inside {LSU_ST_B, LSU_ST_H, LSU_ST_W};
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane strobe/data generation, load extraction and misalign detect
module lsu_align
  import core_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int BYTES = DATA_W / 8,
  localparam int OFF_W = $clog2(BYTES)
) (
  input  lsu_op_t           op,
  input  logic [OFF_W-1:0]  off,
  input  logic [DATA_W-1:0] st_data,
  input  logic [DATA_W-1:0] rdata,
  output logic              is_load,
  output logic              is_store,
  output logic              misaligned,
  output logic [BYTES-1:0]  wstrb,
  output logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] ld_data
);

  logic [OFF_W-1:0]  half_off;
  logic [DATA_W-1:0] byte_sh;
  logic [DATA_W-1:0] half_sh;

  always_comb begin
    half_off   = {off[OFF_W-1:1], 1'b0};
    byte_sh    = rdata >> {off, 3'b000};
    half_sh    = rdata >> {half_off, 3'b000};
    is_load    = lsu_is_load(op);
    is_store   = lsu_is_store(op);
    misaligned = 1'b0;
    wstrb      = '0;
    wdata      = '0;
    ld_data    = rdata;
    case (op)
      LSU_LD_B:  ld_data = {{(DATA_W-BYTE_W){byte_sh[BYTE_W-1]}}, byte_sh[BYTE_W-1:0]};
      LSU_LD_BU: ld_data = {{(DATA_W-BYTE_W){1'b0}}, byte_sh[BYTE_W-1:0]};
      LSU_LD_H: begin
        misaligned = off[0];
        ld_data    = {{(DATA_W-HALF_W){half_sh[HALF_W-1]}}, half_sh[HALF_W-1:0]};
      end
      LSU_LD_HU: begin
        misaligned = off[0];
        ld_data    = {{(DATA_W-HALF_W){1'b0}}, half_sh[HALF_W-1:0]};
      end
      LSU_LD_W:  misaligned = |off;
      // Store data is replicated across lanes so the strobes alone select the target bytes.
      LSU_ST_B: begin
        wstrb = BYTES'(1) << off;
        wdata = {BYTES{st_data[BYTE_W-1:0]}};
      end
      LSU_ST_H: begin
        misaligned = off[0];
        wstrb      = BYTES'(3) << half_off;
        wdata      = {(BYTES/2){st_data[HALF_W-1:0]}};
      end
      LSU_ST_W: begin
        misaligned = |off;
        wstrb      = '1;
        wdata      = st_data;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage between EX/MEM and MEM/WB
module mem_stage
  import core_pkg::*;
#(
  parameter int ADDR_W = XLEN,
  parameter int DATA_W = XLEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ls_valid,
  output logic                  ts_ready,
  input  logic                  ns_ready,
  output logic                  ts_valid,
  input  logic                  flush,
  input  logic                  stall,
  input  logic [ADDR_W-1:0]     in_pc,
  input  logic [31:0]           in_inst,
  input  logic [DATA_W-1:0]     in_ex_result,
  input  logic                  in_rw_en,
  input  logic [4:0]            in_rw_addr,
  input  logic [DATA_W-1:0]     in_lsu_data,
  input  logic [3:0]            in_lsu_op,
  input  logic                  in_csr_rw_en,
  input  logic [13:0]           in_csr_rw_addr,
  input  logic [DATA_W-1:0]     in_csr_rw_data,
  output logic                  dm_req,
  input  logic                  dm_gnt,
  output logic                  dm_we,
  output logic [ADDR_W-1:0]     dm_addr,
  output logic [DATA_W/8-1:0]   dm_wstrb,
  output logic [DATA_W-1:0]     dm_wdata,
  input  logic                  dm_rvalid,
  input  logic [DATA_W-1:0]     dm_rdata,
  output logic [ADDR_W-1:0]     wb_pc,
  output logic [31:0]           wb_inst,
  output logic [DATA_W-1:0]     wb_rw_data,
  output logic                  wb_rw_en,
  output logic [4:0]            wb_rw_addr,
  output logic                  wb_csr_rw_en,
  output logic [13:0]           wb_csr_rw_addr,
  output logic [DATA_W-1:0]     wb_csr_rw_data,
  output logic                  wb_ale,
  output logic [ADDR_W-1:0]     wb_badv
);

  localparam int OFF_W = $clog2(DATA_W / 8);

  mem_state_t        state_q, state_d;
  mem_bundle_t       cap_q, cap_d;
  wb_bundle_t        wb_q, wb_d;
  logic              ts_valid_q, ts_valid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  mem_bundle_t       in_b;
  logic              in_idle, slot_free, accept, is_mem;
  logic              take_direct, take_mem, done_emit;

  lsu_op_t           al_op;
  logic [DATA_W-1:0] al_addr;
  logic              al_is_load, al_is_store, al_mis;
  logic [DATA_W/8-1:0] al_wstrb;
  logic [DATA_W-1:0] al_wdata, al_ld_data;

  always_comb begin
    in_b           = '0;
    in_b.pc        = in_pc;
    in_b.inst      = in_inst;
    in_b.ex_result = in_ex_result;
    in_b.rw_en     = in_rw_en;
    in_b.rw_addr   = in_rw_addr;
    in_b.lsu_data  = in_lsu_data;
    in_b.lsu_op    = lsu_op_t'(in_lsu_op);
    in_b.csr_en    = in_csr_rw_en;
    in_b.csr_addr  = in_csr_rw_addr;
    in_b.csr_data  = in_csr_rw_data;
  end

  // One aligner serves both the incoming bundle (classification in IDLE) and the captured one.
  assign in_idle = (state_q == MS_IDLE);
  assign al_op   = in_idle ? in_b.lsu_op    : cap_q.lsu_op;
  assign al_addr = in_idle ? in_b.ex_result : cap_q.ex_result;

  lsu_align #(.DATA_W(DATA_W)) u_align (
    .op         (al_op),
    .off        (al_addr[OFF_W-1:0]),
    .st_data    (cap_q.lsu_data),
    .rdata      (rdata_q),
    .is_load    (al_is_load),
    .is_store   (al_is_store),
    .misaligned (al_mis),
    .wstrb      (al_wstrb),
    .wdata      (al_wdata),
    .ld_data    (al_ld_data)
  );

  assign slot_free   = !ts_valid_q || ns_ready;
  assign ts_ready    = in_idle && !stall && slot_free;
  assign accept      = ls_valid && ts_ready;
  assign is_mem      = al_is_load || al_is_store;
  assign take_direct = accept && !flush && (!is_mem || al_mis);
  assign take_mem    = accept && !flush && is_mem && !al_mis;
  assign done_emit   = (state_q == MS_DONE) && !flush && slot_free && !stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= MS_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MS_IDLE:  if (take_mem) state_d = MS_REQ;
      MS_REQ: begin
        if (flush)       state_d = dm_gnt ? MS_DRAIN : MS_IDLE;
        else if (dm_gnt) state_d = MS_WAIT;
      end
      // A flush coinciding with the response has nothing left to drain.
      MS_WAIT: begin
        if (flush)          state_d = dm_rvalid ? MS_IDLE : MS_DRAIN;
        else if (dm_rvalid) state_d = MS_DONE;
      end
      MS_DONE:  if (flush || (slot_free && !stall)) state_d = MS_IDLE;
      MS_DRAIN: if (dm_rvalid) state_d = MS_IDLE;
      default:  state_d = MS_IDLE;
    endcase
  end

  always_comb begin
    dm_req   = 1'b0;
    dm_we    = 1'b0;
    dm_addr  = '0;
    dm_wstrb = '0;
    dm_wdata = '0;
    if (state_q == MS_REQ) begin
      dm_req   = 1'b1;
      dm_we    = al_is_store;
      dm_addr  = {cap_q.ex_result[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
      dm_wstrb = al_wstrb;
      dm_wdata = al_wdata;
    end
  end

  always_comb begin
    cap_d      = cap_q;
    rdata_d    = rdata_q;
    wb_d       = wb_q;
    ts_valid_d = ts_valid_q;
    if (take_mem) cap_d = in_b;
    if (state_q == MS_WAIT && dm_rvalid) rdata_d = dm_rdata;
    if (flush) begin
      ts_valid_d = 1'b0;
    end else if (take_direct) begin
      ts_valid_d    = 1'b1;
      wb_d.pc       = in_b.pc;
      wb_d.inst     = in_b.inst;
      wb_d.rw_data  = in_b.ex_result;
      wb_d.rw_en    = in_b.rw_en && !al_mis;
      wb_d.rw_addr  = in_b.rw_addr;
      wb_d.csr_en   = in_b.csr_en && !al_mis;
      wb_d.csr_addr = in_b.csr_addr;
      wb_d.csr_data = in_b.csr_data;
      wb_d.ale      = al_mis;
      wb_d.badv     = al_mis ? in_b.ex_result : '0;
    end else if (done_emit) begin
      ts_valid_d    = 1'b1;
      wb_d.pc       = cap_q.pc;
      wb_d.inst     = cap_q.inst;
      wb_d.rw_data  = al_is_load ? al_ld_data : cap_q.ex_result;
      wb_d.rw_en    = cap_q.rw_en && al_is_load;
      wb_d.rw_addr  = cap_q.rw_addr;
      wb_d.csr_en   = cap_q.csr_en;
      wb_d.csr_addr = cap_q.csr_addr;
      wb_d.csr_data = cap_q.csr_data;
      wb_d.ale      = 1'b0;
      wb_d.badv     = '0;
    end else if (ns_ready && !stall) begin
      ts_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_q      <= '0;
      rdata_q    <= '0;
      wb_q       <= '0;
      ts_valid_q <= 1'b0;
    end else begin
      cap_q      <= cap_d;
      rdata_q    <= rdata_d;
      wb_q       <= wb_d;
      ts_valid_q <= ts_valid_d;
    end
  end

  assign ts_valid       = ts_valid_q;
  assign wb_pc          = wb_q.pc;
  assign wb_inst        = wb_q.inst;
  assign wb_rw_data     = wb_q.rw_data;
  assign wb_rw_en       = wb_q.rw_en;
  assign wb_rw_addr     = wb_q.rw_addr;
  assign wb_csr_rw_en   = wb_q.csr_en;
  assign wb_csr_rw_addr = wb_q.csr_addr;
  assign wb_csr_rw_data = wb_q.csr_data;
  assign wb_ale         = wb_q.ale;
  assign wb_badv        = wb_q.badv;

  // The memory port must return its response at least one cycle after the grant.
  always_ff @(posedge clk) begin
    if (rst && state_q == MS_REQ && dm_gnt) begin
      assert (!dm_rvalid) else $error("mem_stage: dm_rvalid in the same cycle as dm_gnt");
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - randomized self-checking bench for mem_stage against a behavioural model
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ls_valid, ts_ready, ns_ready, ts_valid, flush, stall;
  logic [31:0] in_pc, in_inst, in_ex_result, in_lsu_data, in_csr_rw_data;
  logic        in_rw_en, in_csr_rw_en;
  logic [4:0]  in_rw_addr;
  logic [3:0]  in_lsu_op;
  logic [13:0] in_csr_rw_addr;
  logic        dm_req, dm_gnt, dm_we, dm_rvalid;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_wstrb;
  logic [31:0] wb_pc, wb_inst, wb_rw_data, wb_csr_rw_data, wb_badv;
  logic        wb_rw_en, wb_csr_rw_en, wb_ale;
  logic [4:0]  wb_rw_addr;
  logic [13:0] wb_csr_rw_addr;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_stage dut (
    .clk(clk), .rst(rst), .ls_valid(ls_valid), .ts_ready(ts_ready), .ns_ready(ns_ready),
    .ts_valid(ts_valid), .flush(flush), .stall(stall), .in_pc(in_pc), .in_inst(in_inst),
    .in_ex_result(in_ex_result), .in_rw_en(in_rw_en), .in_rw_addr(in_rw_addr),
    .in_lsu_data(in_lsu_data), .in_lsu_op(in_lsu_op), .in_csr_rw_en(in_csr_rw_en),
    .in_csr_rw_addr(in_csr_rw_addr), .in_csr_rw_data(in_csr_rw_data), .dm_req(dm_req),
    .dm_gnt(dm_gnt), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wstrb(dm_wstrb),
    .dm_wdata(dm_wdata), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .wb_pc(wb_pc),
    .wb_inst(wb_inst), .wb_rw_data(wb_rw_data), .wb_rw_en(wb_rw_en), .wb_rw_addr(wb_rw_addr),
    .wb_csr_rw_en(wb_csr_rw_en), .wb_csr_rw_addr(wb_csr_rw_addr),
    .wb_csr_rw_data(wb_csr_rw_data), .wb_ale(wb_ale), .wb_badv(wb_badv)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Access size in bytes per op code; 0 means no memory access.
  function automatic int op_size(input logic [3:0] op);
    case (op)
      4'd1, 4'd4, 4'd6: return 1;
      4'd2, 4'd5, 4'd7: return 2;
      4'd3, 4'd8:       return 4;
      default:          return 0;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [3:0] op, input logic [31:0] addr,
                                           input logic [31:0] word);
    int unsigned b, h;
    b = (word >> (8 * (addr % 4))) & 32'hFF;
    h = (word >> (16 * ((addr % 4) / 2))) & 32'hFFFF;
    case (op)
      4'd1:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      4'd2:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      4'd4:    return b;
      4'd5:    return h;
      default: return word;
    endcase
  endfunction

  function automatic logic [3:0] ref_strb(input int sz, input logic [31:0] addr);
    int unsigned m;
    if (sz == 4) return 4'hF;
    m = ((1 << sz) - 1) << (addr % 4);
    return 4'(m);
  endfunction

  function automatic logic [31:0] ref_wdata(input int sz, input logic [31:0] d);
    if (sz == 1) return (d & 32'hFF) * 32'h0101_0101;
    if (sz == 2) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  task automatic put(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata);
    ls_valid = 1'b1; in_pc = $urandom; in_inst = $urandom; in_ex_result = addr;
    in_rw_en = 1'b1; in_rw_addr = 5'd5; in_lsu_data = sdata; in_lsu_op = op;
    in_csr_rw_en = 1'b0; in_csr_rw_addr = '0; in_csr_rw_data = '0;
  endtask

  // One complete bundle through the stage with ns_ready=1, stall=0; gw/rw are grant/response delays.
  task automatic do_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                       input logic [31:0] rdata, input int gw, input int rw);
    logic [31:0] pc, inst, cdata;
    logic [4:0]  rd;
    logic [13:0] caddr;
    logic        rwe, cen;
    int sz, t0, n;
    bit is_ld, is_st, mis, mem;
    pc = $urandom; inst = $urandom; cdata = $urandom; rd = 5'($urandom);
    caddr = 14'($urandom); rwe = 1'($urandom); cen = 1'($urandom);
    sz    = op_size(op);
    is_ld = (op >= 4'd1 && op <= 4'd5);
    is_st = (op >= 4'd6 && op <= 4'd8);
    mis   = (sz != 0) && ((addr % sz) != 0);
    mem   = (sz != 0) && !mis;
    @(negedge clk);
    ls_valid = 1'b1; in_pc = pc; in_inst = inst; in_ex_result = addr; in_rw_en = rwe;
    in_rw_addr = rd; in_lsu_data = sdata; in_lsu_op = op; in_csr_rw_en = cen;
    in_csr_rw_addr = caddr; in_csr_rw_data = cdata;
    #1 chk("accept_rdy", ts_ready, 1);
    t0 = cyc;
    @(negedge clk);
    ls_valid = 1'b0;
    if (mem) begin
      #1;
      chk("dm_req", dm_req, 1);
      chk("dm_we", dm_we, is_st);
      chk("dm_addr", dm_addr, addr & ~32'd3);
      if (is_st) begin
        chk("dm_wstrb", dm_wstrb, ref_strb(sz, addr));
        chk("dm_wdata", dm_wdata, ref_wdata(sz, sdata));
      end
      repeat (gw) @(negedge clk);
      #1 chk("req_hold", {dm_req, dm_addr}, {1'b1, addr & ~32'd3});
      dm_gnt = 1'b1;
      @(negedge clk);
      dm_gnt = 1'b0;
      repeat (rw) @(negedge clk);
      #1 chk("req_drop", dm_req, 0);
      dm_rvalid = 1'b1; dm_rdata = rdata;
      @(negedge clk);
      dm_rvalid = 1'b0; dm_rdata = $urandom;
    end else begin
      #1 chk("no_req", dm_req, 0);
    end
    n = 0;
    while (ts_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", cyc - t0, mem ? 4 + gw + rw : 1);
    chk("ts_valid", ts_valid, 1);
    chk("wb_pc", wb_pc, pc);
    chk("wb_inst", wb_inst, inst);
    chk("wb_rw_addr", wb_rw_addr, rd);
    chk("wb_rw_en", wb_rw_en, (mis || is_st) ? 1'b0 : rwe);
    chk("wb_ale", wb_ale, mis);
    chk("wb_csr_en", wb_csr_rw_en, mis ? 1'b0 : cen);
    if (mis) begin
      chk("wb_badv", wb_badv, addr);
    end else begin
      chk("wb_csr_addr", wb_csr_rw_addr, caddr);
      chk("wb_csr_data", wb_csr_rw_data, cdata);
    end
    if (sz == 0) chk("wb_data_alu", wb_rw_data, addr);
    else if (is_ld && !mis) chk("wb_data_ld", wb_rw_data, ref_load(op, addr, rdata));
    @(negedge clk);
    chk("ts_valid_clr", ts_valid, 0);
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] addr, r;
    int sz;
    rst = 1'b0; ls_valid = 1'b0; ns_ready = 1'b1; flush = 1'b0; stall = 1'b0;
    dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = '0;
    put(4'd0, 32'd0, 32'd0);
    ls_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ts_valid", ts_valid, 0);
    chk("rst_dm_req", dm_req, 0);
    chk("rst_wb_rw_en", wb_rw_en, 0);
    chk("rst_wb_data", wb_rw_data, 0);
    rst = 1'b1;
    #1 chk("rst_ts_ready", ts_ready, 1);

    do_op(4'd0, 32'h0000_1234, 32'd0, 32'd0, 0, 0);
    do_op(4'd1, 32'h0000_1003, 32'd0, 32'h80FF_0000, 0, 0);
    do_op(4'd4, 32'h0000_1003, 32'd0, 32'h80FF_0000, 1, 2);
    do_op(4'd7, 32'h0000_2002, 32'h0000_ABCD, 32'd0, 0, 1);
    do_op(4'd3, 32'h0000_3001, 32'd0, 32'd0, 0, 0);

    // Flush while waiting for the response: the late response is swallowed.
    @(negedge clk); put(4'd3, 32'h0000_4000, 32'd0);
    @(negedge clk); ls_valid = 1'b0; dm_gnt = 1'b1;
    @(negedge clk); dm_gnt = 1'b0; flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    #1 chk("drain_rdy0", ts_ready, 0);
    @(negedge clk);
    chk("drain_rdy1", ts_ready, 0);
    dm_rvalid = 1'b1; dm_rdata = $urandom;
    @(negedge clk); dm_rvalid = 1'b0;
    #1 chk("drain_done_rdy", ts_ready, 1);
    chk("drain_no_valid", ts_valid, 0);
    @(negedge clk);
    chk("drain_no_wb", ts_valid, 0);

    // Flush before the grant drops the request outright.
    put(4'd8, 32'h0000_4100, 32'h1111_2222);
    @(negedge clk); ls_valid = 1'b0; flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    #1 chk("reqflush_req", dm_req, 0);
    chk("reqflush_rdy", ts_ready, 1);
    chk("reqflush_valid", ts_valid, 0);

    // Backpressure: result is held while ns_ready=0 and the next bundle waits.
    @(negedge clk); put(4'd5, 32'h0000_5002, 32'd0);
    @(negedge clk); ls_valid = 1'b0; ns_ready = 1'b0; dm_gnt = 1'b1;
    @(negedge clk); dm_gnt = 1'b0; dm_rvalid = 1'b1; dm_rdata = 32'h8001_1234;
    @(negedge clk); dm_rvalid = 1'b0;
    @(negedge clk);
    chk("bp_valid", ts_valid, 1);
    chk("bp_data", wb_rw_data, ref_load(4'd5, 32'h0000_5002, 32'h8001_1234));
    put(4'd0, 32'h0000_0077, 32'd0);
    #1 chk("bp_rdy_low", ts_ready, 0);
    @(negedge clk);
    chk("bp_hold_valid", ts_valid, 1);
    chk("bp_hold_data", wb_rw_data, 32'h0000_8001);
    ns_ready = 1'b1;
    #1 chk("bp_rdy_high", ts_ready, 1);
    @(negedge clk); ls_valid = 1'b0;
    chk("bp_next_valid", ts_valid, 1);
    chk("bp_next_data", wb_rw_data, 32'h0000_0077);

    // Stall holds a finished load in DONE; the bus transaction itself still completes.
    @(negedge clk); put(4'd3, 32'h0000_6000, 32'd0);
    @(negedge clk); ls_valid = 1'b0; stall = 1'b1; dm_gnt = 1'b1;
    @(negedge clk); dm_gnt = 1'b0; dm_rvalid = 1'b1; r = $urandom; dm_rdata = r;
    @(negedge clk); dm_rvalid = 1'b0;
    @(negedge clk);
    chk("stall_hold_valid", ts_valid, 0);
    chk("stall_hold_rdy", ts_ready, 0);
    stall = 1'b0;
    @(negedge clk);
    chk("stall_emit_valid", ts_valid, 1);
    chk("stall_emit_data", wb_rw_data, r);

    for (int i = 0; i < 40; i++) begin
      op   = 4'($urandom_range(0, 8));
      addr = $urandom & 32'h0000_FFFF;
      sz   = op_size(op);
      if (sz != 0 && $urandom_range(0, 2) != 0) addr = addr - (addr % sz);
      do_op(op, addr, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
